// File: rtl/ks_arb_pkg.sv
// ks_arb_pkg: shared constants, state encoding and round-robin pick for ks_adder_arbiter
package ks_arb_pkg;
    localparam int KS_N = 32;
    localparam int KS_RMAX = 8;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} ks_arb_state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } ks_pick_t;

    // Scans downward so the offset closest to ptr wins.
    function automatic ks_pick_t ks_rr_pick(input logic [KS_RMAX-1:0] valid,
                                            input logic [2:0] ptr, input int unsigned r);
        ks_pick_t    pk;
        int unsigned j;
        pk = '0;
        for (int k = KS_RMAX - 1; k >= 0; k--) begin
            j = (32'(ptr) + unsigned'(k)) % r;
            if (unsigned'(k) < r && valid[j[2:0]]) begin
                pk.found = 1'b1;
                pk.idx   = j[2:0];
            end
        end
        return pk;
    endfunction
endpackage

// File: rtl/n_bit_pg_Kogge_Stone_A.sv
// n_bit_pg_Kogge_Stone_A: combinational Kogge-Stone prefix adder with carry in/out
module n_bit_pg_Kogge_Stone_A
    import ks_arb_pkg::*;
#(
    parameter int N = KS_N,
    localparam int LV = $clog2(N)
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);
    logic [N-1:0] g, p, gn, pn;

    always_comb begin
        g = a & b;
        p = a ^ b;
        for (int l = 0; l < LV; l++) begin
            gn = g;
            pn = p;
            for (int i = 1 << l; i < N; i++) begin
                gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
                pn[i] = p[i] & p[i - (1 << l)];
            end
            g = gn;
            p = pn;
        end
    end

    // g/p now hold group terms over bits [i:0]; fold cin in as the carry into bit 0.
    assign s    = a ^ b ^ {g[N-2:0] | (p[N-2:0] & {(N-1){cin}}), cin};
    assign cout = g[N-1] | (p[N-1] & cin);
endmodule

// File: rtl/ks_adder_arbiter.sv
// ks_adder_arbiter: round-robin sharing of one Kogge-Stone adder with registered results
module ks_adder_arbiter
    import ks_arb_pkg::*;
#(
    parameter int N = 32,
    parameter int R = 4,
    localparam int IW = $clog2(R)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [R-1:0]    req_valid,
    output logic [R-1:0]    req_ready,
    input  logic [R*N-1:0]  req_a,
    input  logic [R*N-1:0]  req_b,
    input  logic [R-1:0]    req_sub,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [N-1:0]    res_sum,
    output logic            res_cout,
    output logic            res_ovf,
    output logic [IW-1:0]   res_id,
    output logic            busy
);
    if (N != KS_N) begin : g_bad_n
        $error("ks_adder_arbiter: N must be %0d", KS_N);
    end
    if (R < 2 || R > KS_RMAX) begin : g_bad_r
        $error("ks_adder_arbiter: R must be 2..%0d", KS_RMAX);
    end

    ks_arb_state_t state_q, state_d;
    ks_pick_t      pick;
    logic [IW-1:0] ptr_q, ptr_d, op_id_q, op_id_d, res_id_q, res_id_d, gnt;
    logic [N-1:0]  op_a_q, op_a_d, op_b_q, op_b_d, res_sum_q, res_sum_d, a_g, b_g, s;
    logic [1:0]    op_sgn_q, op_sgn_d;
    logic          op_cin_q, op_cin_d, res_cout_q, res_cout_d, res_ovf_q, res_ovf_d;
    logic          sub_g, cout, can_accept, accept;

    assign pick       = ks_rr_pick(KS_RMAX'(req_valid), 3'(ptr_q), R);
    assign gnt        = IW'(pick.idx);
    assign a_g        = req_a[gnt*N +: N];
    assign b_g        = req_b[gnt*N +: N];
    assign sub_g      = req_sub[gnt];
    assign can_accept = state_q == IDLE || (state_q == DONE && res_ready);
    assign accept     = can_accept && pick.found;
    assign req_ready  = (accept && rst_n) ? R'(1) << gnt : '0;

    n_bit_pg_Kogge_Stone_A #(.N(N)) u_add (
        .a(op_a_q), .b(op_b_q), .cin(op_cin_q), .s(s), .cout(cout)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_cin_d   = op_cin_q;
        op_id_d    = op_id_q;
        op_sgn_d   = op_sgn_q;
        res_sum_d  = res_sum_q;
        res_cout_d = res_cout_q;
        res_ovf_d  = res_ovf_q;
        res_id_d   = res_id_q;
        if (accept) begin
            op_a_d   = a_g;
            op_b_d   = b_g ^ {N{sub_g}};
            op_cin_d = sub_g;
            op_id_d  = gnt;
            op_sgn_d = {a_g[N-1], b_g[N-1] ^ sub_g};
            ptr_d    = (gnt == IW'(R - 1)) ? '0 : gnt + 1'b1;
            state_d  = EXEC;
        end else if (state_q == DONE && res_ready) begin
            state_d = IDLE;
        end
        if (state_q == EXEC) begin
            res_sum_d  = s;
            res_cout_d = cout;
            res_id_d   = op_id_q;
            res_ovf_d  = (op_sgn_q[1] == op_sgn_q[0]) && (s[N-1] != op_sgn_q[1]);
            state_d    = DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_cin_q   <= 1'b0;
            op_id_q    <= '0;
            op_sgn_q   <= '0;
            res_sum_q  <= '0;
            res_cout_q <= 1'b0;
            res_ovf_q  <= 1'b0;
            res_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_cin_q   <= op_cin_d;
            op_id_q    <= op_id_d;
            op_sgn_q   <= op_sgn_d;
            res_sum_q  <= res_sum_d;
            res_cout_q <= res_cout_d;
            res_ovf_q  <= res_ovf_d;
            res_id_q   <= res_id_d;
        end
    end

    assign res_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;
    assign res_ovf   = res_ovf_q;
    assign res_id    = res_id_q;
endmodule

// File: tb/tb_ks_adder_arbiter.sv
// tb_ks_adder_arbiter: directed self-checking bench for ks_adder_arbiter
module tb_ks_adder_arbiter;
    localparam int N = 32;
    localparam int R = 4;

    logic           clk, rst_n, res_valid, res_ready, res_cout, res_ovf, busy;
    logic [R-1:0]   req_valid, req_ready, req_sub;
    logic [R*N-1:0] req_a, req_b;
    logic [N-1:0]   res_sum;
    logic [1:0]     res_id;
    int             total, bad;

    ks_adder_arbiter #(.N(N), .R(R)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .res_valid(res_valid),
        .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout),
        .res_ovf(res_ovf), .res_id(res_id), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic run_op(input int id, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic sub, output int lat);
        @(negedge clk);
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_a[id*N +: N] = a;
        req_b[id*N +: N] = b;
        req_sub[id] = sub;
        @(posedge clk);
        #1 req_valid = '0;
        lat = 1;
        while (!res_valid && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic consume;
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        req_valid = '0; req_sub = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        total++;
        if ({req_ready, res_valid, res_sum, res_cout, res_ovf, res_id, busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {req_ready, res_valid, res_sum, res_cout, res_ovf, res_id, busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        int lat;
        run_op(0, 32'd25, 32'd75, 1'b0, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL add_latency got=%0d exp=2", lat); end
        total++; if (res_sum !== 32'd100) begin bad++; $display("FAIL add_sum got=%h exp=%h", res_sum, 32'd100); end
        total++; if ({res_cout, res_ovf} !== 2'b00) begin bad++; $display("FAIL add_flags got=%b exp=00", {res_cout, res_ovf}); end
        total++; if (res_id !== 2'd0) begin bad++; $display("FAIL add_id got=%0d exp=0", res_id); end
        consume();
    endtask

    task automatic test_sub;
        int lat;
        run_op(1, 32'd5, 32'd7, 1'b1, lat);
        total++; if (res_sum !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub_neg_sum got=%h exp=fffffffe", res_sum); end
        total++; if ({res_cout, res_ovf} !== 2'b00) begin bad++; $display("FAIL sub_neg_flags got=%b exp=00", {res_cout, res_ovf}); end
        total++; if (res_id !== 2'd1) begin bad++; $display("FAIL sub_neg_id got=%0d exp=1", res_id); end
        consume();
        run_op(1, 32'd7, 32'd5, 1'b1, lat);
        total++; if (res_sum !== 32'd2) begin bad++; $display("FAIL sub_pos_sum got=%h exp=2", res_sum); end
        total++; if ({res_cout, res_ovf} !== 2'b10) begin bad++; $display("FAIL sub_pos_flags got=%b exp=10", {res_cout, res_ovf}); end
        consume();
    endtask

    task automatic test_overflow;
        int lat;
        run_op(2, 32'h7FFF_FFFF, 32'd1, 1'b0, lat);
        total++; if (res_sum !== 32'h8000_0000) begin bad++; $display("FAIL ovf_add_sum got=%h exp=80000000", res_sum); end
        total++; if ({res_cout, res_ovf} !== 2'b01) begin bad++; $display("FAIL ovf_add_flags got=%b exp=01", {res_cout, res_ovf}); end
        consume();
        run_op(3, 32'h8000_0000, 32'd1, 1'b1, lat);
        total++; if (res_sum !== 32'h7FFF_FFFF) begin bad++; $display("FAIL ovf_sub_sum got=%h exp=7fffffff", res_sum); end
        total++; if ({res_cout, res_ovf} !== 2'b11) begin bad++; $display("FAIL ovf_sub_flags got=%b exp=11", {res_cout, res_ovf}); end
        consume();
        run_op(3, 32'hFFFF_FFFF, 32'd1, 1'b0, lat);
        total++; if (res_sum !== 32'd0) begin bad++; $display("FAIL wrap_sum got=%h exp=0", res_sum); end
        total++; if ({res_cout, res_ovf} !== 2'b10) begin bad++; $display("FAIL wrap_flags got=%b exp=10", {res_cout, res_ovf}); end
        consume();
    endtask

    task automatic test_fairness;
        logic [R-1:0] exp_rdy;
        @(negedge clk);
        for (int i = 0; i < R; i++) begin
            req_a[i*N +: N] = 32'(i * 16 + 1);
            req_b[i*N +: N] = 32'(i);
        end
        req_sub = '0;
        req_valid = '1;
        res_ready = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            #1;
            exp_rdy = (c % 2 == 0 && c < 10) ? 4'b0001 << ((c / 2) % 4) : 4'b0000;
            total++;
            if (req_ready !== exp_rdy) begin
                bad++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy);
            end
            total++;
            if (res_valid !== (c % 2 == 0 && c >= 2)) begin
                bad++; $display("FAIL rr_valid c=%0d got=%b", c, res_valid);
            end
            if (c % 2 == 0 && c >= 2) begin
                total++;
                if (res_id !== 2'((c / 2 - 1) % 4) || res_sum !== 32'(((c / 2 - 1) % 4) * 17 + 1)) begin
                    bad++; $display("FAIL rr_result c=%0d got id=%0d sum=%0d exp id=%0d", c, res_id, res_sum, (c / 2 - 1) % 4);
                end
            end
            if (c == 9) req_valid = '0;
            @(negedge clk);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [N-1:0] held;
        run_op(2, 32'd100, 32'd1, 1'b1, lat);
        held = 32'd99;
        req_valid[2] = 1'b1;
        req_a[2*N +: N] = 32'd40;
        req_b[2*N +: N] = 32'd2;
        req_sub[2] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (res_sum !== held || res_id !== 2'd2 || res_cout !== 1'b1 || res_valid !== 1'b1 ||
                req_ready !== 4'b0000 || busy !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold c=%0d got sum=%0d id=%0d v=%b rdy=%b busy=%b", c, res_sum, res_id, res_valid, req_ready, busy);
            end
        end
        @(negedge clk);
        res_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL bp_accept got=%b exp=0100", req_ready); end
        @(posedge clk);
        #1 req_valid = '0;
        res_ready = 1'b0;
        total++; if (res_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL bp_exec got v=%b busy=%b exp v=0 busy=1", res_valid, busy); end
        @(posedge clk);
        #1;
        total++;
        if (res_valid !== 1'b1 || res_sum !== 32'd42 || res_id !== 2'd2) begin
            bad++; $display("FAIL bp_result got v=%b sum=%0d id=%0d exp v=1 sum=42 id=2", res_valid, res_sum, res_id);
        end
        consume();
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        req_valid = 4'b0010;
        req_a[1*N +: N] = 32'd1;
        req_b[1*N +: N] = 32'd2;
        req_sub = '0;
        @(posedge clk);
        #2;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL arst_pre_busy got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({req_ready, res_valid, res_sum, res_cout, res_ovf, res_id, busy} !== '0) begin
            bad++;
            $display("FAIL arst_outputs got=%h exp=0",
                     {req_ready, res_valid, res_sum, res_cout, res_ovf, res_id, busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b1010;
        req_a[1*N +: N] = 32'd3;
        req_b[1*N +: N] = 32'd4;
        req_a[3*N +: N] = 32'd9;
        req_b[3*N +: N] = 32'd9;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL arst_ptr got=%b exp=0010", req_ready); end
        @(posedge clk);
        #1 req_valid = '0;
        @(posedge clk);
        #1;
        total++;
        if (res_valid !== 1'b1 || res_id !== 2'd1 || res_sum !== 32'd7) begin
            bad++; $display("FAIL arst_result got v=%b id=%0d sum=%0d exp v=1 id=1 sum=7", res_valid, res_id, res_sum);
        end
        consume();
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_fairness();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ks_adder_arbiter.md
# ks_adder_arbiter

Round-robin arbiter and sequencer that shares one 32-bit Kogge-Stone adder (`n_bit_pg_Kogge_Stone_A`) among R requesters, with add/subtract and signed-overflow reporting.

- Registers the operands of the granted request.
- Drives the shared adder from those registers.
- Captures the sum into a result register held under valid/ready backpressure.

It sits between requesting datapath units and the combinational adder, so that only one adder instance is needed.

## Interface
Parameters:
- `N`, 32: operand width. The adder is fixed-width, so any other value is illegal; the block asserts this at elaboration.
- `R`, 4: number of requesters, 2..8.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  R  request pending, one bit per requester.
- `req_ready`  out  R  one-hot accept; at most one bit high per cycle.
- `req_a`  in  R*N  operand A; requester i uses bits [i*N +: N].
- `req_b`  in  R*N  operand B, same packing as `req_a`.
- `req_sub`  in  R  1 = A−B, 0 = A+B.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_sum`  out  N  sum or difference.
- `res_cout`  out  1  adder carry out; for subtract, 1 = no borrow.
- `res_ovf`  out  1  two's-complement overflow.
- `res_id`  out  $clog2(R)  index of the requester that produced the result.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: no operation held.
  - EXEC: operands registered, adder evaluating.
  - DONE: result held.
- Arbitration:
  - `ptr` (width $clog2(R)) is the highest-priority index.
  - The grant goes to the first i with `req_valid[i]`=1, scanning from `ptr` upward with wrap.
  - After a grant to i, `ptr` ← (i+1) mod R.
  - Arbitration happens only when the block can accept a request: in IDLE, or in DONE in the same cycle that `res_ready`=1.
- Accept, when `req_valid[g] & req_ready[g]`:
  - `op_a` ← A_g.
  - `op_b` ← B_g XOR {N{sub_g}}.
  - `op_cin` ← sub_g.
  - `op_id` ← g.
  - `op_sgn` ← {A_g[N-1], op_b[N-1]} (the register value just written), kept for overflow.
  - State → EXEC.
- EXEC (one cycle, unconditional):
  - `res_sum` ← S, `res_cout` ← Cout, `res_id` ← `op_id`.
  - `res_ovf` ← (A_g[N-1] == op_b[N-1]) & (S[N-1] != A_g[N-1]).
  - State → DONE.
- DONE:
  - `res_valid`=1; all result outputs are stable until the handshake.
  - If `res_ready`=0, the block stays in DONE and all `req_ready`=0.
  - If `res_ready`=1 and any `req_valid`, the block accepts the next request and goes to EXEC (back-to-back).
  - If `res_ready`=1 and no `req_valid`, the block goes to IDLE.
- Arithmetic wraps modulo 2^N.
  - `res_cout` is the raw adder Cout.
  - For subtract, `res_cout`=1 means A ≥ B unsigned.
- Requester rules:
  - Dropping `req_valid` before acceptance is legal and has no effect.
  - Operands are sampled only on the accept edge.
- Reset (asynchronous, at any time, including mid-EXEC or mid-DONE):
  - State → IDLE, `ptr`=0.
  - All outputs 0: `req_ready`, `res_valid`, `res_sum`, `res_cout`, `res_ovf`, `res_id`, `busy`.
  - Any in-flight operation is discarded.

## Timing
- `req_ready` is combinational from state, `ptr`, `req_valid` and `res_ready`. There is no combinational path from `req_a`/`req_b` to any output.
- Latency: accept at edge k gives `res_valid`=1 after edge k+1. The result appears 2 cycles after the cycle the request is presented.
- Throughput: 1 result per 2 cycles with `res_ready` held high.
- The adder path runs from registers (`op_a`, `op_b`, `op_cin`) to registers (`res_sum`, `res_cout`, `res_ovf`): one full cycle for the 5-level prefix tree.
- Fairness: with all R requesters continuously valid, each is granted exactly once in every R consecutive grants.

## Structure
- Package `ks_arb_pkg`:
  - `KS_N` = 32.
  - State enum `ks_arb_state_t` {IDLE, EXEC, DONE}.
  - Function `ks_rr_pick(valid, ptr)` returning the grant index plus a found flag.
- Sub-module: exactly one instance of `n_bit_pg_Kogge_Stone_A`, inputs from the operand registers. No other sub-modules; the arbiter logic is inline.

## Test plan
- Add: req0 A=25, B=75, sub=0, Cin=0 → `res_sum`=100, `res_cout`=0, `res_ovf`=0, `res_id`=0, `res_valid` 2 cycles after presentation.
- Subtract:
  - req1 A=5, B=7, sub=1 → `res_sum`=0xFFFFFFFE, `res_cout`=0, `res_ovf`=0, `res_id`=1.
  - A=7, B=5 → `res_sum`=2, `res_cout`=1.
- Overflow:
  - A=0x7FFFFFFF + B=1 → `res_sum`=0x80000000, `res_ovf`=1.
  - A=0xFFFFFFFF + B=1 → `res_sum`=0, `res_cout`=1, `res_ovf`=0.
- Fairness: all 4 requesters valid, `res_ready` high → grants and `res_id` sequence 0,1,2,3,0; each `req_ready` is one-hot; results every 2 cycles.
- Backpressure: `res_ready` low for 5 cycles in DONE → result outputs constant, `req_ready`=0, `busy`=1; raising `res_ready` with req2 valid accepts req2 in that same cycle.
- Reset: assert `rst_n`=0 mid-EXEC → all outputs 0 immediately (asynchronous); after release, the first grant goes to the lowest valid index (`ptr`=0).
